iq_avg_sequencer: RTL and testbench

- Controls a pair of block averagers, one on I and one on Q, that share one sample strobe. Drives their reset and load strobes and captures each completed I/Q average pair.
- Presents captured pairs on a valid/ready stream toward the AXI/DMA side, with run/abort/done and overrun status for the PS.
- Sits between the DDC sample-valid strobe and the averager instances.

---
 rtl/iq_avg_sequencer.sv | 135 +++++++++++++
 tb/tb_iq_avg_sequencer.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iq_avg_sequencer.sv
// Sequencer for a lock-stepped pair of I/Q block averagers: gates their load/clear
// strobes, captures each finished {Q, I} average and streams it out on valid/ready.
module iq_avg_sequencer #(
  parameter int NBITS   = 32,
  parameter int CNTBITS = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [CNTBITS-1:0]   num_windows,
  input  logic                 s_valid,
  input  logic                 avg_valid,
  input  logic [NBITS-1:0]     avg_i,
  input  logic [NBITS-1:0]     avg_q,
  output logic                 avg_rst,
  output logic                 avg_load,
  output logic [2*NBITS-1:0]   m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 busy,
  output logic                 done,
  output logic                 overrun,
  output logic [CNTBITS-1:0]   win_count
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CLEAR = 2'd1;
  localparam logic [1:0] RUN   = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  localparam logic [CNTBITS-1:0] CNT_MAX = '1;
  localparam logic [CNTBITS-1:0] CNT_ONE = CNTBITS'(1);

  logic [1:0]           state_reg, state_next;
  logic [CNTBITS-1:0]   num_windows_reg, num_windows_next;
  logic [CNTBITS-1:0]   win_count_reg, win_count_next;
  logic                 overrun_reg, overrun_next;
  logic                 done_reg, done_next;
  logic                 m_valid_reg, m_valid_next;
  logic [2*NBITS-1:0]   pair_in;
  logic                 window_done;
  logic                 slot_free;
  logic                 capture;

  // Abort kills the load in its own cycle so the partial window never completes.
  assign avg_load    = (state_reg == RUN) && s_valid && !abort;
  assign avg_rst     = (state_reg != RUN);
  assign window_done = avg_valid && avg_load;
  assign slot_free   = !m_valid_reg || m_ready;
  assign capture     = window_done && slot_free;
  assign pair_in     = {avg_q, avg_i};

  assign busy      = (state_reg != IDLE);
  assign done      = done_reg;
  assign overrun   = overrun_reg;
  assign win_count = win_count_reg;
  assign m_valid   = m_valid_reg;

  always_comb begin
    state_next       = state_reg;
    num_windows_next = num_windows_reg;
    win_count_next   = win_count_reg;
    overrun_next     = overrun_reg;
    done_next        = 1'b0;
    m_valid_next     = m_valid_reg;

    if (m_valid_reg && m_ready) m_valid_next = 1'b0;
    if (capture)                m_valid_next = 1'b1;

    case (state_reg)
      IDLE: begin
        if (start && !abort) begin
          state_next       = CLEAR;
          num_windows_next = num_windows;
          win_count_next   = '0;
          overrun_next     = 1'b0;
        end
      end
      CLEAR: begin
        state_next = abort ? IDLE : RUN;
        done_next  = abort;
      end
      RUN: begin
        if (abort) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end else if (window_done) begin
          if (!slot_free) overrun_next = 1'b1;
          if (win_count_reg != CNT_MAX) win_count_next = win_count_reg + CNT_ONE;
          if ((num_windows_reg != '0) && (win_count_next == num_windows_reg))
            state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (abort || !m_valid_reg) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      num_windows_reg <= '0;
      win_count_reg   <= '0;
      overrun_reg     <= 1'b0;
      done_reg        <= 1'b0;
      m_valid_reg     <= 1'b0;
    end else begin
      state_reg       <= state_next;
      num_windows_reg <= num_windows_next;
      win_count_reg   <= win_count_next;
      overrun_reg     <= overrun_next;
      done_reg        <= done_next;
      m_valid_reg     <= m_valid_next;
    end
  end

  // One holding lane per channel; a dropped pair leaves both lanes untouched.
  for (genvar gi = 0; gi < 2; gi++) begin : g_lane
    logic [NBITS-1:0] lane_reg;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       lane_reg <= '0;
      else if (capture) lane_reg <= pair_in[gi*NBITS +: NBITS];
    end

    assign m_data[gi*NBITS +: NBITS] = lane_reg;
  end

endmodule

// File: tb/tb_iq_avg_sequencer.sv
// Bench for iq_avg_sequencer: a behavioural 321-sample averager pair feeds the DUT,
// a scoreboard checks every streamed pair, plus a control table and corner sequences.
module tb_iq_avg_sequencer;

  localparam int NBITS   = 32;
  localparam int CNTBITS = 16;
  localparam int WIN     = 321;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                start = 1'b0;
  logic                abort = 1'b0;
  logic [CNTBITS-1:0]  num_windows = '0;
  logic                s_valid = 1'b0;
  logic                avg_valid;
  logic [NBITS-1:0]    avg_i;
  logic [NBITS-1:0]    avg_q;
  logic                avg_rst;
  logic                avg_load;
  logic [2*NBITS-1:0]  m_data;
  logic                m_valid;
  logic                m_ready = 1'b0;
  logic                busy;
  logic                done;
  logic                overrun;
  logic [CNTBITS-1:0]  win_count;

  iq_avg_sequencer #(.NBITS(NBITS), .CNTBITS(CNTBITS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .num_windows(num_windows),
    .s_valid(s_valid), .avg_valid(avg_valid), .avg_i(avg_i), .avg_q(avg_q),
    .avg_rst(avg_rst), .avg_load(avg_load), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .busy(busy), .done(done), .overrun(overrun), .win_count(win_count)
  );

  always #5 clk = ~clk;

  // Averager pair model: the average is only meaningful on the completing cycle,
  // outside it the outputs carry noise so a mistimed capture shows up.
  int          acc_cnt;
  int unsigned seed;
  logic [31:0] noise;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_cnt <= 0;
      seed    <= 0;
      noise   <= 32'h1234_5678;
    end else begin
      noise <= noise * 32'd1103515245 + 32'd12345;
      if (avg_rst) acc_cnt <= 0;
      else if (avg_load) begin
        if (acc_cnt == WIN - 1) begin
          acc_cnt <= 0;
          seed    <= seed + 1;
        end else acc_cnt <= acc_cnt + 1;
      end
    end
  end

  assign avg_valid = (acc_cnt == WIN - 1);

  always_comb begin
    if (avg_valid) begin
      avg_i = 32'h1000_0000 + seed * 32'd7;
      avg_q = 32'h2000_0000 ^ (seed * 32'd13 + 32'd5);
    end else begin
      avg_i = noise;
      avg_q = ~noise;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, {63'b0, act}, {63'b0, exp});
  endtask

  task automatic chkc(input string name, input logic [CNTBITS-1:0] act, input int exp);
    chk(name, {48'b0, act}, 64'(exp));
  endtask

  // Scoreboard: a completing window is expected on the stream only if the slot is free.
  logic [63:0] exp_q[$];
  int          transfers = 0;
  int          loads = 0;
  bit          hold_vld = 0;
  logic [63:0] hold_data;

  always @(negedge clk) begin
    if (rst_n) begin
      if (m_valid && hold_vld) chk("m_data stable under backpressure", m_data, hold_data);
      if (m_valid && m_ready) begin
        transfers++;
        $display("xfer %0d: m_data=0x%016h", transfers, m_data);
        if (exp_q.size() == 0) begin
          chk1("unexpected transfer", 1'b1, 1'b0);
        end else begin
          chk("m_data vs scoreboard", m_data, exp_q.pop_front());
        end
      end
      hold_vld  = m_valid && !m_ready;
      hold_data = m_data;
      if (avg_valid && avg_load && !abort && (!m_valid || m_ready))
        exp_q.push_back({avg_q, avg_i});
      if (avg_load) loads++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  bit drain_seen;

  task automatic wait_done(input string name, input int budget);
    bit got = 0;
    bit ran = 0;
    drain_seen = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (busy && !avg_rst) ran = 1;
      else if (busy && ran) begin
        drain_seen = 1;
        chk1({name, " avg_load in DRAIN"}, avg_load, 1'b0);
      end
      if (done) begin
        got = 1;
        break;
      end
    end
    chk1({name, " done within budget"}, got, 1'b1);
  endtask

  task automatic wait_wins(input string name, input int target, input int budget);
    bit got = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (win_count == CNTBITS'(target)) begin
        got = 1;
        break;
      end
    end
    chk1({name, " win_count reached"}, got, 1'b1);
  endtask

  typedef struct packed {
    logic start, abort, s_valid;
    logic busy, avg_rst, avg_load, done;
  } vec_t;

  vec_t vecs [14];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, l0;
    bit hit;

    // Reset values while rst_n is held low.
    @(negedge clk);
    chk1("reset avg_rst", avg_rst, 1'b1);
    chk1("reset avg_load", avg_load, 1'b0);
    chk1("reset m_valid", m_valid, 1'b0);
    chk1("reset busy", busy, 1'b0);
    chk1("reset done", done, 1'b0);
    chk1("reset overrun", overrun, 1'b0);
    chk("reset m_data", m_data, 64'd0);
    chkc("reset win_count", win_count, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Control table: start+abort in IDLE, start during RUN, abort in RUN, abort in IDLE.
    //            start abort s_valid | busy avg_rst avg_load done
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    m_ready = 1'b1;
    num_windows = '0;
    for (int i = 0; i < 14; i++) begin
      step();
      start   = vecs[i].start;
      abort   = vecs[i].abort;
      s_valid = vecs[i].s_valid;
      @(negedge clk);
      chk1($sformatf("row%0d busy", i), busy, vecs[i].busy);
      chk1($sformatf("row%0d avg_rst", i), avg_rst, vecs[i].avg_rst);
      chk1($sformatf("row%0d avg_load", i), avg_load, vecs[i].avg_load);
      chk1($sformatf("row%0d done", i), done, vecs[i].done);
    end
    step();
    start = 1'b0; abort = 1'b0; s_valid = 1'b0;
    @(negedge clk);
    chkc("table win_count", win_count, 0);
    chk1("table m_valid", m_valid, 1'b0);

    // Two windows, continuous samples, no backpressure; num_windows change mid-run ignored.
    t0 = transfers;
    step();
    num_windows = 16'd2; s_valid = 1'b1; m_ready = 1'b1; start = 1'b1;
    step();
    start = 1'b0; num_windows = 16'd7;
    wait_done("run2", 1500);
    chk1("run2 drain seen", drain_seen, 1'b1);
    chkc("run2 win_count", win_count, 2);
    @(negedge clk);
    chk1("run2 done one cycle", done, 1'b0);
    chk1("run2 idle avg_load", avg_load, 1'b0);
    chk1("run2 idle avg_rst", avg_rst, 1'b1);
    chk1("run2 idle busy", busy, 1'b0);
    repeat (2) @(negedge clk);
    chk("run2 transfers", 64'(transfers - t0), 64'd2);
    chk("run2 scoreboard empty", 64'(exp_q.size()), 64'd0);

    // Backpressure: three windows with m_ready low, first pair held, later pairs dropped.
    step();
    num_windows = 16'd3; m_ready = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    wait_wins("bp2", 2, 1000);
    chk1("bp overrun after 2nd", overrun, 1'b1);
    chk1("bp m_valid held", m_valid, 1'b1);
    chk("bp scoreboard depth", 64'(exp_q.size()), 64'd1);
    if (exp_q.size() > 0) chk("bp held pair", m_data, exp_q[0]);
    wait_wins("bp3", 3, 1000);
    repeat (3) step();
    @(negedge clk);
    chk1("bp drain busy", busy, 1'b1);
    chk1("bp drain avg_load", avg_load, 1'b0);
    chk1("bp drain avg_rst", avg_rst, 1'b1);
    chk1("bp drain m_valid", m_valid, 1'b1);
    chk1("bp drain no done", done, 1'b0);
    chkc("bp win_count", win_count, 3);
    step();
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    @(negedge clk);
    chk1("bp m_valid cleared", m_valid, 1'b0);
    chk1("bp done not yet", done, 1'b0);
    @(negedge clk);
    chk1("bp done pulse", done, 1'b1);
    chk1("bp idle", busy, 1'b0);
    @(negedge clk);
    chk1("bp done one cycle", done, 1'b0);
    chk1("bp overrun sticky", overrun, 1'b1);

    // Abort on the 100th load of the first window in continuous mode.
    t0 = transfers;
    l0 = loads;
    step();
    num_windows = '0; m_ready = 1'b1; s_valid = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    repeat (100) step();
    abort = 1'b1;
    @(negedge clk);
    chk1("abort100 avg_load", avg_load, 1'b0);
    step();
    abort = 1'b0;
    @(negedge clk);
    chk1("abort100 done", done, 1'b1);
    chk1("abort100 busy", busy, 1'b0);
    chk1("abort100 avg_rst", avg_rst, 1'b1);
    chk1("abort100 m_valid", m_valid, 1'b0);
    chkc("abort100 win_count", win_count, 0);
    chk1("abort100 overrun cleared by start", overrun, 1'b0);
    repeat (2) @(negedge clk);
    chk("abort100 loads", 64'(loads - l0), 64'd99);
    chk("abort100 transfers", 64'(transfers - t0), 64'd0);

    // Fresh run after the abort must produce one full-length window.
    l0 = loads;
    step();
    num_windows = 16'd1; start = 1'b1;
    step();
    start = 1'b0;
    wait_done("rerun", 1000);
    chkc("rerun win_count", win_count, 1);
    repeat (2) @(negedge clk);
    chk("rerun loads", 64'(loads - l0), 64'(WIN));
    chk("rerun transfers", 64'(transfers - t0), 64'd1);
    chk("rerun scoreboard empty", 64'(exp_q.size()), 64'd0);

    // Abort exactly on the completing cycle of window 2.
    t0 = transfers;
    step();
    num_windows = '0; start = 1'b1;
    step();
    start = 1'b0;
    wait_wins("avabort w1", 1, 500);
    hit = 0;
    for (int c = 0; c < 500; c++) begin
      step();
      if (avg_valid) begin
        abort = 1'b1;
        hit = 1;
        break;
      end
    end
    chk1("avabort reached avg_valid", hit, 1'b1);
    @(negedge clk);
    chk1("avabort avg_load", avg_load, 1'b0);
    step();
    abort = 1'b0; s_valid = 1'b0;
    @(negedge clk);
    chk1("avabort done", done, 1'b1);
    chkc("avabort win_count", win_count, 1);
    repeat (3) @(negedge clk);
    chk1("avabort m_valid", m_valid, 1'b0);
    chk("avabort transfers", 64'(transfers - t0), 64'd1);
    chk("avabort scoreboard empty", 64'(exp_q.size()), 64'd0);

    // Asynchronous reset mid-RUN with a pair held in the output register.
    step();
    num_windows = '0; m_ready = 1'b0; s_valid = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    hit = 0;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      if (m_valid) begin
        hit = 1;
        break;
      end
    end
    chk1("arst m_valid before reset", hit, 1'b1);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk1("arst m_valid", m_valid, 1'b0);
    chk1("arst avg_rst", avg_rst, 1'b1);
    chk1("arst avg_load", avg_load, 1'b0);
    chk1("arst busy", busy, 1'b0);
    chk1("arst done", done, 1'b0);
    chk1("arst overrun", overrun, 1'b0);
    chk("arst m_data", m_data, 64'd0);
    chkc("arst win_count", win_count, 0);
    exp_q.delete();
    s_valid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk1("arst stays idle", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
